// File: rtl/ram_dp_pkg.sv
// ==========================================================================
// ram_dp_pkg : halfword width and index-width helper for the dual-port RAM
// Rev 1.0
// ==========================================================================
`default_nettype none

package ram_dp_pkg;

  localparam int c_hw_width = 16;

  // Number of index bits needed to address n entries.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_hw_array.sv
// ==========================================================================
// ram_hw_array : halfword array, one burst write port, two burst read ports
// Rev 1.0
// ==========================================================================
`default_nettype none

module ram_hw_array
  import ram_dp_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int BURST = 2,
  parameter int IDX_W = clog2(DEPTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          we_i,
  input  logic [IDX_W-1:0]              wbase_i,
  input  logic [c_hw_width*BURST-1:0]   wdata_i,
  input  logic [IDX_W-1:0]              rbase_a_i,
  output logic [c_hw_width*BURST-1:0]   rdata_a_o,
  input  logic [IDX_W-1:0]              rbase_b_i,
  output logic [c_hw_width*BURST-1:0]   rdata_b_o
);

  logic [c_hw_width-1:0] words [DEPTH];

  // Lane indices are IDX_W wide, so bursts past the top wrap to index 0.
  always_ff @(posedge clk_i) begin
    if (rst_ni && we_i) begin
      for (int k = 0; k < BURST; k++) begin
        words[wbase_i + IDX_W'(k)] <= wdata_i[k*c_hw_width +: c_hw_width];
      end
    end
  end

  for (genvar k = 0; k < BURST; k++) begin : g_lane
    logic [IDX_W-1:0] w_ra_idx;
    logic [IDX_W-1:0] w_rb_idx;
    assign w_ra_idx = rbase_a_i + IDX_W'(k);
    assign w_rb_idx = rbase_b_i + IDX_W'(k);
    assign rdata_a_o[k*c_hw_width +: c_hw_width] = words[w_ra_idx];
    assign rdata_b_o[k*c_hw_width +: c_hw_width] = words[w_rb_idx];
  end

endmodule

`default_nettype wire

// File: rtl/ram_dp.sv
// ==========================================================================
// ram_dp : dual-port halfword RAM, word-addressed data port, halfword fetch
// Rev 1.0
// ==========================================================================
`default_nettype none

module ram_dp
  import ram_dp_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int BURST      = 2,
  parameter int ADDR_WIDTH = 31
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          write_en,
  input  logic [ADDR_WIDTH-1:0]         iaddr,
  input  logic [ADDR_WIDTH-1:0]         daddr,
  input  logic [c_hw_width*BURST-1:0]   data_i,
  output logic [c_hw_width*BURST-1:0]   data_o,
  output logic [c_hw_width*BURST-1:0]   inst_o
);

  localparam int c_idx_w = clog2(DEPTH);

  logic [c_idx_w-1:0] w_dbase;
  logic [c_idx_w-1:0] w_ibase;
  logic               w_unused;

  // Data port is word addressed: halfword base is daddr*2, truncated to the array.
  assign w_dbase  = {daddr[c_idx_w-2:0], 1'b0};
  assign w_ibase  = iaddr[c_idx_w-1:0];
  assign w_unused = ^{daddr[ADDR_WIDTH-1:c_idx_w-1], iaddr[ADDR_WIDTH-1:c_idx_w]};

  ram_hw_array #(
    .DEPTH (DEPTH),
    .BURST (BURST),
    .IDX_W (c_idx_w)
  ) mem_inst (
    .clk_i     (clock),
    .rst_ni    (reset),
    .we_i      (write_en),
    .wbase_i   (w_dbase),
    .wdata_i   (data_i),
    .rbase_a_i (w_dbase),
    .rdata_a_o (data_o),
    .rbase_b_i (w_ibase),
    .rdata_b_o (inst_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_dp.sv
// ==========================================================================
// tb_ram_dp : directed self-checking bench for ram_dp (BURST=2, DEPTH=1024)
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_ram_dp;

  logic        clock;
  logic        reset;
  logic        write_en;
  logic [30:0] iaddr;
  logic [30:0] daddr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [31:0] inst_o;

  int n_checks;
  int n_pass;

  ram_dp #(
    .DEPTH      (1024),
    .BURST      (2),
    .ADDR_WIDTH (31)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .write_en (write_en),
    .iaddr    (iaddr),
    .daddr    (daddr),
    .data_i   (data_i),
    .data_o   (data_o),
    .inst_o   (inst_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic wr(input logic [30:0] a, input logic [31:0] d);
    daddr    = a;
    data_i   = d;
    write_en = 1'b1;
    @(posedge clock);
    #1;
    write_en = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    write_en = 1'b0;
    iaddr    = '0;
    daddr    = '0;
    data_i   = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    // Basic write, aligned and misaligned fetch of the same data
    wr(31'h10, 32'hDEADBEEF);
    iaddr = 31'h20;
    #1;
    chk("wr_data_o", data_o, 32'hDEADBEEF);
    chk("wr_inst_o", inst_o, 32'hDEADBEEF);
    iaddr = 31'h21;
    #1;
    chk("misal_lo", {16'h0, inst_o[15:0]}, 32'h0000DEAD);

    // Misaligned fetch across a word boundary
    wr(31'h0, 32'h22221111);
    wr(31'h1, 32'h44443333);
    iaddr = 31'h1;
    #1;
    chk("fetch_1", inst_o, 32'h33332222);
    chk("data_1", data_o, 32'h44443333);
    iaddr = 31'h0;
    #1;
    chk("fetch_0", inst_o, 32'h22221111);

    // Reset suppresses writes; reads stay live during reset
    reset = 1'b0;
    wr(31'h10, 32'h12345678);
    iaddr = 31'h20;
    #1;
    chk("rst_data_o", data_o, 32'hDEADBEEF);
    chk("rst_inst_o", inst_o, 32'hDEADBEEF);
    reset = 1'b1;

    // Upper address bits truncated: word 0x200 aliases word 0
    wr(31'h0, 32'hAAAA5555);
    daddr = 31'h200;
    #1;
    chk("wrap_daddr", data_o, 32'hAAAA5555);
    daddr = 31'h600;
    iaddr = 31'h400;
    #1;
    chk("wrap_daddr_hi", data_o, 32'hAAAA5555);
    chk("wrap_iaddr", inst_o, 32'hAAAA5555);

    // Fetch burst wraps from the last halfword to halfword 0
    wr(31'h1FF, 32'hBBBB7777);
    iaddr = 31'h3FF;
    #1;
    chk("wrap_burst", inst_o, 32'h5555BBBB);

    // Read-during-write: old data before the edge, new after
    wr(31'h5, 32'h01234567);
    iaddr    = 31'd10;
    daddr    = 31'd5;
    data_i   = 32'hCAFEF00D;
    write_en = 1'b1;
    #1;
    chk("rdw_inst_old", inst_o, 32'h01234567);
    chk("rdw_data_old", data_o, 32'h01234567);
    @(posedge clock);
    #1;
    write_en = 1'b0;
    chk("rdw_inst_new", inst_o, 32'hCAFEF00D);
    chk("rdw_data_new", data_o, 32'hCAFEF00D);

    // No write without write_en
    data_i = 32'h0;
    @(posedge clock);
    #1;
    chk("no_we", data_o, 32'hCAFEF00D);

    // Reset asserted with write_en on the same edge leaves memory unchanged
    reset = 1'b0;
    wr(31'h5, 32'h55AA55AA);
    reset = 1'b1;
    #1;
    chk("rst_same_edge", data_o, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
- REQ-001 SHALL have parameter DEPTH, default 1024: storage size in 16-bit halfwords, a power of two.
- REQ-002 SHALL have parameter BURST, default 2: halfwords per access; port data width W = 16*BURST.
- REQ-003 SHALL have parameter ADDR_WIDTH, default 31: width of both address ports.
- REQ-004 SHALL have port clock, input, 1: the single clock; all writes occur on its rising edge.
- REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
- REQ-006 SHALL have port write_en, input, 1: data-port write strobe.
- REQ-007 SHALL have port iaddr, input, ADDR_WIDTH: instruction-port halfword address.
- REQ-008 SHALL have port daddr, input, ADDR_WIDTH: data-port word address; halfword base = daddr*2.
- REQ-009 SHALL have port data_i, input, W: write data.
- REQ-010 SHALL have port data_o, output, W: data-port read data.
- REQ-011 SHALL have port inst_o, output, W: instruction-port read data.

Function
- REQ-012 Storage SHALL be DEPTH halfwords; only the low log2(DEPTH) bits of each computed halfword index are used, so indices wrap modulo DEPTH.
- REQ-013 data_o SHALL be the little-endian concatenation of halfwords [daddr*2 + k], k = 0..BURST-1: halfword k occupies bits 16k+15:16k.
- REQ-014 inst_o SHALL be the concatenation of halfwords [iaddr + k], k = 0..BURST-1, in the same order; any halfword alignment is legal (compressed-instruction fetch).
- REQ-015 Both reads SHALL be combinational from the addresses and the current array contents, with zero-cycle latency and no read enable.
- REQ-016 When reset is high and write_en is 1 at a rising clock edge, halfword k of data_i SHALL be written to index daddr*2 + k for all k in the same edge.
- REQ-017 Read during write SHALL return old contents before the edge and new contents after it, on both ports.
- REQ-018 The two ports SHALL be independent; identical or overlapping addresses on both ports SHALL both return identical data.
- REQ-019 Burst wrap-around past index DEPTH-1 SHALL continue at index 0 for both reads and writes.
- REQ-020 Storage contents SHALL be initialisable by a simulator memory-load of the halfword array; no built-in initial contents are required, and uninitialised reads are don't-care.

Reset
- REQ-021 While reset is low, writes SHALL be suppressed.
- REQ-022 Reset SHALL NOT clear the storage array.
- REQ-023 Reads SHALL remain functional during reset, because outputs are combinational and not reset.
- REQ-024 Reset asserted on the same edge as write_en SHALL leave memory unchanged.

Structure
- REQ-025 ram_dp SHALL instantiate one sub-module ram_hw_array, with instance name mem_inst, holding the halfword array named words.
- REQ-026 ram_hw_array SHALL provide one write port and two read ports.
- REQ-027 The shared package SHALL hold only the halfword width constant (16) and the index-width function clog2(DEPTH); no typedefs are required.
- REQ-028 Index arithmetic SHALL be done at log2(DEPTH) bits, truncating the upper address bits.

Verification (BURST=2, DEPTH=1024)
- REQ-029 Write daddr=0x10, data_i=0xDEADBEEF, reset high; next cycle data_o=0xDEADBEEF; iaddr=0x20 gives inst_o=0xDEADBEEF; iaddr=0x21 gives inst_o[15:0]=0xDEAD.
- REQ-030 Pre-load halfwords [0]=0x1111, [1]=0x2222, [2]=0x3333; iaddr=1 gives inst_o=0x33332222 (misaligned fetch).
- REQ-031 Hold reset low, write_en=1, daddr=0x10, data_i=0x12345678; after the edge, data_o remains 0xDEADBEEF.
- REQ-032 Write daddr=0x0 with 0xAAAA5555, then set daddr=0x200 (index 0x400 wraps to 0); data_o=0xAAAA5555.
- REQ-033 Set iaddr=0x3FF; inst_o[15:0]=halfword[0x3FF] and inst_o[31:16]=halfword[0] (wrap).
- REQ-034 Same edge: write daddr=5 with 0xCAFEF00D while iaddr=10; inst_o shows old value before the edge and 0xCAFEF00D after it.
